// File: rtl/uart_rx_pkt_ctrl.sv
// rtl/uart_rx_pkt_ctrl.sv - packet framer behind the UART receiver: SOF/LEN/payload/CSUM with checked release
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SOF           = 8'hA5,
    parameter int         MAX_LEN       = 16,
    parameter int         TIMEOUT_TICKS = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic [7:0] ovr_cnt
);

    localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         TW        = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    wr_idx_q, wr_idx_d;
    logic [7:0]    rd_idx_q, rd_idx_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic          err_pulse_q, err_pulse_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    ovr_cnt_q, ovr_cnt_d;

    logic [7:0]    pay_mem_q [MAX_LEN];
    logic          pay_we;

    logic          timer_active;
    logic          timeout;
    logic [7:0]    sum_plus;
    logic [7:0]    wr_next;
    logic [7:0]    rd_next;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        sum_d        = sum_q;
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        tick_cnt_d   = tick_cnt_q;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        m_last_d     = m_last_q;
        err_pulse_d  = 1'b0;
        err_code_d   = err_code_q;
        ovr_cnt_d    = ovr_cnt_q;
        pay_we       = 1'b0;

        sum_plus     = sum_q + rx_data;
        wr_next      = wr_idx_q + 8'd1;
        rd_next      = rd_idx_q + 8'd1;
        timer_active = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);
        // A byte landing on the terminal tick wins over the timeout
        timeout      = timer_active && !rx_done_tick && s_tick &&
                       (tick_cnt_q == TW'(TIMEOUT_TICKS - 1));

        if (!timer_active || rx_done_tick) begin
            tick_cnt_d = '0;
        end else if (s_tick) begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rx_done_tick && rx_data == SOF) begin
                    state_d = ST_LEN;
                    sum_d   = 8'd0;
                end
            end
            ST_LEN: begin
                if (rx_done_tick) begin
                    sum_d = rx_data;
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        err_code_d  = 2'b01;
                        err_pulse_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        len_d    = rx_data;
                        wr_idx_d = 8'd0;
                        state_d  = ST_PAYLOAD;
                    end
                end else if (timeout) begin
                    err_code_d  = 2'b11;
                    err_pulse_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (rx_done_tick) begin
                    pay_we   = 1'b1;
                    sum_d    = sum_plus;
                    wr_idx_d = wr_next;
                    if (wr_next == len_q) begin
                        state_d = ST_CSUM;
                    end
                end else if (timeout) begin
                    err_code_d  = 2'b11;
                    err_pulse_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_CSUM: begin
                if (rx_done_tick) begin
                    if (sum_plus == 8'd0) begin
                        state_d   = ST_DRAIN;
                        rd_idx_d  = 8'd0;
                        m_valid_d = 1'b1;
                        m_data_d  = pay_mem_q[0];
                        m_last_d  = (len_q == 8'd1);
                    end else begin
                        err_code_d  = 2'b10;
                        err_pulse_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (timeout) begin
                    err_code_d  = 2'b11;
                    err_pulse_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (rx_done_tick && ovr_cnt_q != 8'hFF) begin
                    ovr_cnt_d = ovr_cnt_q + 8'd1;
                end
                if (m_valid_q && m_ready) begin
                    if (m_last_q) begin
                        state_d   = ST_IDLE;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end else begin
                        rd_idx_d = rd_next;
                        m_data_d = pay_mem_q[rd_next[IDX_W-1:0]];
                        m_last_d = (rd_next == len_q - 8'd1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= 8'd0;
            sum_q       <= 8'd0;
            wr_idx_q    <= 8'd0;
            rd_idx_q    <= 8'd0;
            tick_cnt_q  <= '0;
            m_data_q    <= 8'd0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 2'b00;
            ovr_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            tick_cnt_q  <= tick_cnt_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    // Payload storage needs no reset: only indices written this packet are ever read
    always_ff @(posedge clk) begin
        if (pay_we) begin
            pay_mem_q[wr_idx_q[IDX_W-1:0]] <= rx_data;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign err_pulse = err_pulse_q;
    assign err_code  = err_code_q;
    assign ovr_cnt   = ovr_cnt_q;

endmodule
